// File: rtl/mux4_arbiter.sv
// Four-way round-robin arbiter that muxes the owning requester's data onto out.
// Define MUX4_ARBITER_TIMEOUT_EN to add the grant hold timeout and requester masking.
module mux4_arbiter #(
  parameter int WIDTH    = 64,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       grant,
  output logic             sel1,
  output logic             sel0,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic             expired
);

  typedef enum logic {IDLE, OWN} state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic       busy_q, busy_d;
  logic [3:0] elig;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

`ifdef MUX4_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD = 8'(HOLD_MAX);
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic       exp_q, exp_d;

  assign elig    = req & ~mask_q;
  assign expired = exp_q;
`else
  assign elig    = req;
  assign expired = 1'b0;
`endif

  // Search starts one past the last owner and wraps.
  always_comb begin
    pick  = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    last_d  = last_q;
    busy_d  = busy_q;
`ifdef MUX4_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    mask_d  = mask_q & req;
    exp_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          grant_d = 4'b0001 << pick;
          idx_d   = pick;
          busy_d  = 1'b1;
`ifdef MUX4_ARBITER_TIMEOUT_EN
          cnt_d   = 8'd1;
`endif
        end
      end
      OWN: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          last_d  = idx_q;
`ifdef MUX4_ARBITER_TIMEOUT_EN
          cnt_d   = 8'd0;
        end else if (cnt_q >= HOLD) begin
          state_d        = IDLE;
          grant_d        = 4'b0000;
          busy_d         = 1'b0;
          last_d         = idx_q;
          cnt_d          = 8'd0;
          mask_d[idx_q]  = 1'b1;
          exp_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      busy_q  <= 1'b0;
`ifdef MUX4_ARBITER_TIMEOUT_EN
      cnt_q   <= 8'd0;
      mask_q  <= 4'b0000;
      exp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef MUX4_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
`endif
    end
  end

  logic [WIDTH-1:0] mux;

  always_comb begin
    mux = '0;
    unique case (idx_q)
      2'd0: mux = data0;
      2'd1: mux = data1;
      2'd2: mux = data2;
      2'd3: mux = data3;
    endcase
  end

  assign grant = grant_q;
  assign sel1  = idx_q[1];
  assign sel0  = idx_q[0];
  assign busy  = busy_q;
  assign out   = busy_q ? mux : '0;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Randomized and directed checks of mux4_arbiter against a behavioural model.
module tb_mux4_arbiter;
  localparam int W  = 64;
  localparam int HM = 4;
`ifdef MUX4_ARBITER_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [W-1:0] data0, data1, data2, data3;
  logic [3:0]   grant;
  logic         sel1, sel0, busy, expired;
  logic [W-1:0] out;

  int errs   = 0;
  int checks = 0;

  int own, last, cnt, msel;
  bit mexp;
  bit mask [4];

  logic [3:0]   eg;
  logic [W-1:0] eo;

  mux4_arbiter #(.WIDTH(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .grant(grant), .sel1(sel1), .sel0(sel0), .busy(busy),
    .out(out), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dat(input int i);
    case (i)
      0: return data0;
      1: return data1;
      2: return data2;
      default: return data3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    own  = -1;
    last = 3;
    cnt  = 0;
    msel = 0;
    mexp = 1'b0;
    for (int i = 0; i < 4; i++) mask[i] = 1'b0;
  endfunction

  // One clock edge of the arbitration rules, using req as sampled there.
  function automatic void model_step(input logic [3:0] r);
    int nxt;
    mexp = 1'b0;
    nxt  = -1;
    if (own < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (last + k) % 4;
        if (nxt < 0 && r[i] && !mask[i]) nxt = i;
      end
      if (nxt >= 0) begin
        own  = nxt;
        msel = nxt;
        cnt  = 1;
      end
    end else if (!r[own]) begin
      last = own;
      own  = -1;
    end else if (TO && cnt >= HM) begin
      mask[own] = 1'b1;
      last = own;
      own  = -1;
      mexp = 1'b1;
    end else begin
      cnt++;
    end
    for (int i = 0; i < 4; i++) if (!r[i] && i != nxt) mask[i] = 1'b0;
  endfunction

  always @(posedge clk) if (!reset) model_step(req);

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      eg = (own < 0) ? 4'b0000 : (4'b0001 << own);
      eo = (own < 0) ? '0 : dat(own);
      chk("grant", 64'(grant), 64'(eg));
      chk("busy", 64'(busy), 64'(own >= 0));
      chk("sel", 64'({sel1, sel0}), 64'(msel));
      chk("out", out, eo);
      chk("expired", 64'(expired), 64'(mexp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    data0 = 64'h0000_0000_0000_0A00;
    data1 = 64'h0000_0000_0000_0B11;
    data2 = 64'h0000_0000_0000_0C22;
    data3 = 64'h0000_0000_0000_0D33;
    model_reset();
    #3;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_sel", 64'({sel1, sel0}), 64'h0);
    chk("rst_out", out, 64'h0);
    chk("rst_expired", 64'(expired), 64'h0);
    tick();
    tick();
    reset = 1'b0;

    req = 4'b1111; tick();
    chk("all_first", 64'(grant), 64'h1);
    chk("all_sel", 64'({sel1, sel0}), 64'h0);
    req = 4'b1110; tick();
    chk("turnaround", 64'(grant), 64'h0);
    tick();
    chk("next_rr", 64'(grant), 64'h2);

    req = 4'b1010; tick(); chk("hold_a", 64'(grant), 64'h2);
    req = 4'b0010; tick(); chk("hold_b", 64'(grant), 64'h2);
    req = 4'b1010; tick(); chk("hold_c", 64'(grant), 64'h2);
    req = 4'b1000; tick(); chk("rel1", 64'(grant), 64'h0);
    tick(); chk("own3", 64'(grant), 64'h8);
    req = 4'b0000; tick();

    data2 = 64'hDEAD_BEEF_0000_0002;
    req = 4'b0100; tick();
    chk("sel1_2", 64'(sel1), 64'h1);
    chk("sel0_2", 64'(sel0), 64'h0);
    chk("busy_2", 64'(busy), 64'h1);
    chk("out_2", out, 64'hDEAD_BEEF_0000_0002);

    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_grant", 64'(grant), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_out", out, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst", 64'(grant), 64'h4);
    req = 4'b0000; tick(); tick();

    do_reset();
    req = 4'b1001; tick(); chk("p_a1", 64'(grant), 64'h1);
    tick(); tick(); chk("p_a3", 64'(grant), 64'h1);
    req = 4'b1000; tick(); chk("p_gap1", 64'(grant), 64'h0);
    tick(); chk("p_b1", 64'(grant), 64'h8);
    tick(); tick(); chk("p_b3", 64'(grant), 64'h8);
    req = 4'b0001; tick(); chk("p_gap2", 64'(grant), 64'h0);
    tick(); chk("p_c1", 64'(grant), 64'h1);
    req = 4'b0000; tick(); tick();

`ifdef MUX4_ARBITER_TIMEOUT_EN
    do_reset();
    req = 4'b0011; tick(); chk("to_g0", 64'(grant), 64'h1);
    tick(); tick(); tick(); chk("to_g0_4", 64'(grant), 64'h1);
    tick();
    chk("to_revoke", 64'(grant), 64'h0);
    chk("to_exp", 64'(expired), 64'h1);
    tick();
    chk("to_g1", 64'(grant), 64'h2);
    chk("to_exp_end", 64'(expired), 64'h0);
    req = 4'b0001; tick(); chk("to_rel1", 64'(grant), 64'h0);
    tick(); chk("to_masked", 64'(grant), 64'h0);
    req = 4'b0000; tick();
    req = 4'b0001; tick(); chk("to_unmask", 64'(grant), 64'h1);
    req = 4'b0000; tick(); tick();
`endif

    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) req[b] = ~req[b];
      data0 = {$urandom, $urandom};
      data1 = {$urandom, $urandom};
      data2 = {$urandom, $urandom};
      data3 = {$urandom, $urandom};
      if ($urandom_range(299) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        chk("rnd_rst_grant", 64'(grant), 64'h0);
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 64, the data width of each requester port.
REQ-002 The block SHALL expose parameter HOLD_MAX, default 16, the maximum number of cycles a grant is held when the timeout is compiled in (legal range 1..255).
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1; reset SHALL be asynchronous and active-high.
REQ-005 Port req, input, 4; req[i] high means requester i wants the shared path and holds it while high.
REQ-006 Ports data0, data1, data2, data3, input, WIDTH each; the operand of requesters 0..3.
REQ-007 Port grant, output, 4, one-hot or zero; grant[i] high means requester i owns the path.
REQ-008 Ports sel1 and sel0, output, 1 each; the mux select, {sel1,sel0} equals the owner index.
REQ-009 Port busy, output, 1; high when any grant is active.
REQ-010 Port out, output, WIDTH; the owner's data when busy, else all zeros.
REQ-011 Port expired, output, 1; a one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 The FSM SHALL have states IDLE and OWN.
REQ-013 In IDLE with any req bit high, the FSM SHALL go to OWN at the next edge and register the winner's one-hot grant and index.
REQ-014 The winner SHALL be chosen round-robin: search starts at (last_owner+1) mod 4 and ascends with wrap-around.
REQ-015 Grant, sel1/sel0 and busy SHALL be registered; they become visible one cycle after req is sampled.
REQ-016 out SHALL be combinational from the registered index and dataN, with zero added latency.
REQ-017 In OWN, when req[owner] is sampled low, the FSM SHALL return to IDLE with grant=0 for exactly one turnaround cycle before any new grant.
REQ-018 In OWN, req changes from non-owners SHALL NOT affect the grant.
REQ-019 last_owner SHALL update to the owner index on every exit from OWN.
REQ-020 sel1/sel0 SHALL hold their last value while IDLE; only busy and grant indicate validity.
REQ-021 At most one grant bit SHALL be high in any cycle.

Reset
REQ-022 Asserting reset SHALL immediately force state IDLE, grant=0, busy=0, out=0, sel1=sel0=0, expired=0, hold counter=0, mask=0, and last_owner=3, so that requester 0 has first priority.
REQ-023 Reset asserted mid-grant SHALL drop the grant without a turnaround cycle, and the first arbitration after deassertion SHALL follow REQ-014 with last_owner=3.

Configuration
REQ-024 Macro MUX4_ARBITER_TIMEOUT_EN SHALL select whether the hold timeout is compiled in.
REQ-025 With the macro defined, an 8-bit counter SHALL count cycles in OWN. When it reaches HOLD_MAX, the grant SHALL be revoked at the next edge, expired SHALL pulse for one cycle, and the FSM SHALL enter IDLE.
REQ-026 With the macro defined, a revoked requester SHALL be masked from arbitration until its req is sampled low.
REQ-027 With the macro undefined, grants SHALL be held indefinitely, expired SHALL be tied to 0, and no counter or mask logic SHALL exist.

Verification
REQ-028 Reset, then req=4'b1111 -> grant=0001, sel=00 on the next cycle; after owner 0 releases: one cycle grant=0, then grant=0010.
REQ-029 req=4'b1001 held, each owner releasing after 3 cycles -> grant order 0001, 1000, 0001, with a one-cycle grant=0 gap between each.
REQ-030 data2=64'hDEAD_BEEF_0000_0002, req=4'b0100 -> sel1=1, sel0=0, busy=1, out=64'hDEAD_BEEF_0000_0002; otherwise out=0.
REQ-031 Owner 1 granted, req[3] toggles -> grant stays 0010 until req[1] falls.
REQ-032 Timeout (macro on, HOLD_MAX=4), req=4'b0011 held -> owner 0 revoked after 4 cycles, expired=1 for one cycle, then grant=0010; requester 0 is not regranted until it drops and re-raises req.
REQ-033 Reset asserted while grant=0100 -> grant=0, busy=0 immediately; after release with req=4'b0100 -> grant=0100 on the next edge.
